axis_partition_cutter: RTL and testbench
========================================

Name: axis_partition_cutter

Overview:
- Downstream stage of the packet-partition path.
- Consumes one segment descriptor at a time, in the format {id_ext, addr, len_m1} that the partitioner's descriptor FIFO produces.
- Cuts a continuous input data stream into segments of exactly len_m1+1 beats, asserting out_last on each segment's final beat and tagging beats with the segment id.
- Signals segment completion back through a done handshake, which the partitioner uses as its per-partition pulse.

Parameters:
- DSIZE, 32: data beat width.
- LSIZE, 8: length field width; field holds beats-1.
- IDSIZE, 4: base id width. Descriptor id field is IDSIZE+4 bits.
- ASIZE, 20: address field width.

Ports:
- clock  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- desc_data  input  IDSIZE+4+ASIZE+LSIZE  {id_ext, addr, len_m1}, MSB first
- desc_valid  input  1  descriptor valid
- desc_ready  output  1  descriptor ready
- in_data  input  DSIZE  input beat
- in_valid  input  1  input valid
- in_last  input  1  upstream end-of-stream marker
- in_ready  output  1  input ready
- out_data  output  DSIZE  output beat
- out_valid  output  1  output valid
- out_last  output  1  last beat of the current segment
- out_id  output  IDSIZE+4  id_ext of the current segment
- out_addr  output  ASIZE  addr of the current segment, held for the whole segment
- done_valid  output  1  segment-complete handshake valid
- done_ready  input  1  segment-complete handshake ready
- err_short  output  1  sticky: upstream in_last arrived before the segment length was reached
- stall_flag  output  1  watchdog flag (optional feature)

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clock. All outputs reset to 0. The FSM enters IDLE, and desc_ready becomes 1 on the first clock edge after reset release. Reset asserted mid-segment discards the segment with no done pulse and clears err_short.
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE: desc_ready=1. On desc_valid&&desc_ready go to LOAD.
- desc_ready is registered and decoded from the next state: it drops in the same cycle as the handshake edge, so at most one descriptor is accepted per segment.
- LOAD (1 cycle):
  - latch id_ext, addr and len_m1;
  - beat_cnt := 0;
  - next state is STREAM.
- STREAM:
  - Output stage is a single register: in_ready = ~out_valid | out_ready. Input-to-output latency is 1 cycle.
  - Each accepted input beat loads the output register: out_data=in_data, out_id=id, out_addr=addr. It also sets out_last = (beat_cnt==len_m1) | in_last, and increments beat_cnt.
  - On the beat that sets out_last, in_ready is forced to 0 from the next cycle, and the FSM moves to DRAIN.
- DRAIN: wait until the output register empties (out_valid&&out_ready on the last beat, or out_valid already 0), then go to DONE.
- DONE: done_valid=1 until done_valid&&done_ready, then go to IDLE.
- Short stream: if in_last arrives with beat_cnt<len_m1, the segment still ends on that beat with out_last=1, and err_short is set and stays set until reset.
- Normal end: in_last on the exact final beat (beat_cnt==len_m1) is a normal end; err_short is not set.
- in_last need not appear at segment boundaries: a long stream is cut across several descriptors.
- Width rules:
  - beat_cnt is LSIZE bits; the comparison is equality only.
  - len_m1=0 produces a 1-beat segment. len_m1=2^LSIZE-1 produces 2^LSIZE beats with no counter wrap issue, because the terminal compare precedes the increment.
- Simultaneous events: a done handshake in the same cycle as a new desc_valid does not accept the descriptor; the new descriptor is accepted from IDLE on a later cycle.
- No beat is passed through outside STREAM: in_ready=0 in IDLE, LOAD, DRAIN and DONE.

Optional Feature:
- Macro: AXIS_PARTITION_CUTTER_WATCHDOG_EN.
- When defined: a 10-bit counter increments each cycle in STREAM or DONE with no handshake on in or done, and clears on any handshake or state change. stall_flag=1 while the count exceeds 200 in STREAM or 1000 in DONE.
- When not defined: the counter is absent and stall_flag is tied to 0.

Decomposition:
- Package axis_partition_pkg holds:
  - the FSM state enum;
  - the descriptor width function IDSIZE+4+ASIZE+LSIZE;
  - the field slice helpers;
  - the watchdog thresholds 200 and 1000.
- One sub-module, axis_partition_out_reg: a single-entry output register with valid/ready, carrying data, last, id and addr.

Test Plan:
- Nominal cut: descriptor len_m1=3, id 0x15, addr 0x00040; 4 input beats D0..D3, out_ready=1 → out_last only on D3, out_id=0x15, one done pulse, desc_ready high again 1 cycle after the done handshake.
- Back-pressure: len_m1=7 with out_ready toggling 1,0,0,1,… → all 8 beats emitted in order, no loss or duplication; in_ready low whenever out_valid&&~out_ready.
- Short stream: len_m1=9 with in_last on the 5th beat → out_last on beat 5, err_short=1, done pulse issued, next descriptor processed normally.
- Stream spanning segments: three descriptors of len_m1=127 plus one of len_m1=63, against a 448-beat stream with in_last only on beat 448 → out_last on beats 128, 256, 384 and 448; err_short stays 0.
- Edge lengths: len_m1=0 → 1-beat segment with out_last=1; len_m1=255 (LSIZE=8) → 256 beats, last on beat 256.
- Reset mid-segment: assert rst_n=0 after beat 2 of len_m1=5 → all outputs 0 immediately, no done pulse; after release, a fresh descriptor completes correctly.

Source files
------------

// File: rtl/axis_partition_pkg.sv
// Shared types and helpers for the partition cutter: FSM states, descriptor layout
// {id_ext, addr, len_m1} and watchdog thresholds.
package axis_partition_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int unsigned WD_STREAM_MAX = 200;
   localparam int unsigned WD_DONE_MAX   = 1000;

   function automatic int desc_width(input int idsize, input int asize, input int lsize);
      return idsize + 4 + asize + lsize;
   endfunction

   // LSB positions of each descriptor field; len_m1 sits at the bottom.
   function automatic int len_lsb();
      return 0;
   endfunction

   function automatic int addr_lsb(input int lsize);
      return lsize;
   endfunction

   function automatic int id_lsb(input int asize, input int lsize);
      return asize + lsize;
   endfunction

endpackage

// File: rtl/axis_partition_out_reg.sv
// Single-entry output register with valid/ready carrying data, last, id and addr.
module axis_partition_out_reg #(
   parameter int DSIZE = 32,
   parameter int IDW   = 8,
   parameter int ASIZE = 20
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [DSIZE-1:0] data_i,
   input  logic             last_i,
   input  logic [IDW-1:0]   id_i,
   input  logic [ASIZE-1:0] addr_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [DSIZE-1:0] data_o,
   output logic             last_o,
   output logic [IDW-1:0]   id_o,
   output logic [ASIZE-1:0] addr_o
);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         valid_o <= 1'b0;
         data_o  <= '0;
         last_o  <= 1'b0;
         id_o    <= '0;
         addr_o  <= '0;
      end else if (load_i) begin
         valid_o <= 1'b1;
         data_o  <= data_i;
         last_o  <= last_i;
         id_o    <= id_i;
         addr_o  <= addr_i;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_partition_cutter.sv
// Cuts an input beat stream into descriptor-sized segments with out_last and id tagging.
// Optional stall watchdog enabled by defining AXIS_PARTITION_CUTTER_WATCHDOG_EN.
module axis_partition_cutter
   import axis_partition_pkg::*;
#(
   parameter int DSIZE  = 32,
   parameter int LSIZE  = 8,
   parameter int IDSIZE = 4,
   parameter int ASIZE  = 20
) (
   input  logic                                clock,
   input  logic                                rst_n,
   input  logic [IDSIZE+4+ASIZE+LSIZE-1:0]     desc_data,
   input  logic                                desc_valid,
   output logic                                desc_ready,
   input  logic [DSIZE-1:0]                    in_data,
   input  logic                                in_valid,
   input  logic                                in_last,
   output logic                                in_ready,
   output logic [DSIZE-1:0]                    out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                out_last,
   output logic [IDSIZE+3:0]                   out_id,
   output logic [ASIZE-1:0]                    out_addr,
   output logic                                done_valid,
   input  logic                                done_ready,
   output logic                                err_short,
   output logic                                stall_flag
);

   localparam int IDW  = IDSIZE + 4;
   localparam int DW   = desc_width(IDSIZE, ASIZE, LSIZE);
   localparam int LLSB = len_lsb();
   localparam int ALSB = addr_lsb(LSIZE);
   localparam int ILSB = id_lsb(ASIZE, LSIZE);

   state_e             state_q, state_d;
   logic               desc_ready_q;
   logic [IDW-1:0]     id_q, id_d;
   logic [ASIZE-1:0]   addr_q, addr_d;
   logic [LSIZE-1:0]   len_q, len_d;
   logic [LSIZE-1:0]   beat_cnt_q, beat_cnt_d;
   logic               err_short_q, err_short_d;
   logic [DW-1:0]      desc_w;
   logic               desc_fire, in_fire, seg_end, done_fire;

   assign desc_w     = desc_data;
   assign desc_fire  = desc_valid & desc_ready_q;
   assign in_ready   = (state_q == ST_STREAM) & (~out_valid | out_ready);
   assign in_fire    = in_valid & in_ready;
   // Terminal compare happens before the increment, so len_m1 = all-ones never wraps early.
   assign seg_end    = (beat_cnt_q == len_q) | in_last;
   assign done_valid = (state_q == ST_DONE);
   assign done_fire  = done_valid & done_ready;
   assign desc_ready = desc_ready_q;
   assign err_short  = err_short_q;

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      addr_d      = addr_q;
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      err_short_d = err_short_q;
      case (state_q)
         ST_IDLE: begin
            if (desc_fire) begin
               id_d    = desc_w[ILSB +: IDW];
               addr_d  = desc_w[ALSB +: ASIZE];
               len_d   = desc_w[LLSB +: LSIZE];
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            beat_cnt_d = '0;
            state_d    = ST_STREAM;
         end
         ST_STREAM: begin
            if (in_fire) begin
               beat_cnt_d = beat_cnt_q + LSIZE'(1);
               if (seg_end) begin
                  state_d = ST_DRAIN;
                  if (in_last && (beat_cnt_q != len_q)) err_short_d = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (!out_valid || out_ready) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (done_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         desc_ready_q <= 1'b0;
         id_q         <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         beat_cnt_q   <= '0;
         err_short_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         // Decoded from the next state so it drops on the accepting edge itself.
         desc_ready_q <= (state_d == ST_IDLE);
         id_q         <= id_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         beat_cnt_q   <= beat_cnt_d;
         err_short_q  <= err_short_d;
      end
   end

   axis_partition_out_reg #(
      .DSIZE (DSIZE),
      .IDW   (IDW),
      .ASIZE (ASIZE)
   ) u_out_reg (
      .clock   (clock),
      .rst_n   (rst_n),
      .load_i  (in_fire),
      .data_i  (in_data),
      .last_i  (seg_end),
      .id_i    (id_q),
      .addr_i  (addr_q),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .data_o  (out_data),
      .last_o  (out_last),
      .id_o    (out_id),
      .addr_o  (out_addr)
   );

`ifdef AXIS_PARTITION_CUTTER_WATCHDOG_EN
   logic [9:0] wd_q, wd_d;

   always_comb begin
      wd_d = wd_q;
      if ((state_d != state_q) || in_fire || done_fire) begin
         wd_d = '0;
      end else if (((state_q == ST_STREAM) || (state_q == ST_DONE)) && (wd_q != '1)) begin
         wd_d = wd_q + 10'd1;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) wd_q <= '0;
      else        wd_q <= wd_d;
   end

   assign stall_flag = ((state_q == ST_STREAM) && (wd_q > 10'(WD_STREAM_MAX))) ||
                       ((state_q == ST_DONE)   && (wd_q > 10'(WD_DONE_MAX)));
`else
   assign stall_flag = 1'b0;
`endif

endmodule

// File: tb/tb_axis_partition_cutter.sv
// Scoreboard bench for axis_partition_cutter: expected beats queued at input acceptance.
module tb_axis_partition_cutter;

   localparam int DSIZE = 32;
   localparam int LSIZE = 8;
   localparam int IDSIZE = 4;
   localparam int ASIZE = 20;
   localparam int IDW = IDSIZE + 4;

   logic                          clock = 1'b0;
   logic                          rst_n = 1'b0;
   logic [IDW+ASIZE+LSIZE-1:0]    desc_data = '0;
   logic                          desc_valid = 1'b0;
   logic                          desc_ready;
   logic [DSIZE-1:0]              in_data = '0;
   logic                          in_valid = 1'b0;
   logic                          in_last = 1'b0;
   logic                          in_ready;
   logic [DSIZE-1:0]              out_data;
   logic                          out_valid;
   logic                          out_ready = 1'b1;
   logic                          out_last;
   logic [IDW-1:0]                out_id;
   logic [ASIZE-1:0]              out_addr;
   logic                          done_valid;
   logic                          done_ready = 1'b1;
   logic                          err_short;
   logic                          stall_flag;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [7:0]  id;
      logic [19:0] addr;
   } beat_t;

   beat_t       sb[$];
   beat_t       mon_e;
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          cyc = 0;
   bit          bp_mode = 1'b0;
   logic [31:0] data_ctr = 32'hD000_0000;

   axis_partition_cutter #(
      .DSIZE(DSIZE), .LSIZE(LSIZE), .IDSIZE(IDSIZE), .ASIZE(ASIZE)
   ) dut (
      .clock(clock), .rst_n(rst_n),
      .desc_data(desc_data), .desc_valid(desc_valid), .desc_ready(desc_ready),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .out_id(out_id), .out_addr(out_addr),
      .done_valid(done_valid), .done_ready(done_ready),
      .err_short(err_short), .stall_flag(stall_flag)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Downstream ready: pattern 1,0,0,1 while back-pressure is enabled.
   always @(posedge clock) begin
      #2;
      cyc++;
      if (bp_mode) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else         out_ready = 1'b1;
   end

   always @(negedge clock) begin
      #1;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_nonempty", 64'(sb.size()), 64'd1);
            end else begin
               mon_e = sb.pop_front();
               chk("out_data", 64'(out_data), 64'(mon_e.data));
               chk("out_last", 64'(out_last), 64'(mon_e.last));
               chk("out_id",   64'(out_id),   64'(mon_e.id));
               chk("out_addr", 64'(out_addr), 64'(mon_e.addr));
               $display("beat data=%08h last=%0d id=%02h addr=%05h", out_data, out_last, out_id, out_addr);
            end
         end
         if (out_valid && !out_ready) chk("in_ready_bp", 64'(in_ready), 64'd0);
         if (done_valid && done_ready) done_cnt++;
      end
   end

   task automatic send_desc(input logic [7:0] id, input logic [19:0] addr, input logic [7:0] len);
      int n;
      n = 0;
      @(negedge clock);
      desc_data  = {id, addr, len};
      desc_valid = 1'b1;
      #1;
      while (!desc_ready && n < 1000) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk("desc_timeout", 64'(n >= 1000), 64'd0);
      @(posedge clock);
      #1;
      desc_valid = 1'b0;
      $display("desc id=%02h addr=%05h len_m1=%0d", id, addr, len);
   endtask

   task automatic send_beats(input int n, input int last_at, input logic [7:0] len,
                             input logic [7:0] id, input logic [19:0] addr);
      for (int k = 0; k < n; k++) begin
         int    w;
         beat_t e;
         w = 0;
         @(negedge clock);
         in_data  = data_ctr;
         in_last  = (k == last_at);
         in_valid = 1'b1;
         #1;
         while (!in_ready && w < 2000) begin
            @(negedge clock);
            #1;
            w++;
         end
         if (w >= 2000) chk("in_timeout", 64'(w), 64'd0);
         e.data = data_ctr;
         e.last = (k == int'(len)) || (k == last_at);
         e.id   = id;
         e.addr = addr;
         sb.push_back(e);
         data_ctr = data_ctr + 32'd1;
         @(posedge clock);
         #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic finish_seg(input int exp_done);
      int w;
      w = 0;
      @(negedge clock);
      #1;
      while (!(done_valid && done_ready) && w < 2000) begin
         @(negedge clock);
         #1;
         w++;
      end
      chk("done_timeout", 64'(w >= 2000), 64'd0);
      @(negedge clock);
      #1;
      chk("desc_ready_after_done", 64'(desc_ready), 64'd1);
      chk("in_ready_idle", 64'(in_ready), 64'd0);
      chk("done_count", 64'(done_cnt), 64'(exp_done));
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("segment done count=%0d", done_cnt);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_valid"},  64'(out_valid), 64'd0);
      chk({tag, "_out_last"},   64'(out_last), 64'd0);
      chk({tag, "_out_data"},   64'(out_data), 64'd0);
      chk({tag, "_out_id"},     64'(out_id), 64'd0);
      chk({tag, "_out_addr"},   64'(out_addr), 64'd0);
      chk({tag, "_desc_ready"}, 64'(desc_ready), 64'd0);
      chk({tag, "_in_ready"},   64'(in_ready), 64'd0);
      chk({tag, "_done_valid"}, 64'(done_valid), 64'd0);
      chk({tag, "_err_short"},  64'(err_short), 64'd0);
      chk({tag, "_stall_flag"}, 64'(stall_flag), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation bound exceeded");
   end

   initial begin
      int seg_len;
      int seg_last;
      int saved_done;
      repeat (3) @(negedge clock);
      #1;
      chk_all_zero("reset");
      @(negedge clock);
      rst_n = 1'b1;
      #1;
      chk("desc_ready_pre_edge", 64'(desc_ready), 64'd0);
      @(negedge clock);
      #1;
      chk("desc_ready_post_edge", 64'(desc_ready), 64'd1);

      // Nominal cut
      send_desc(8'h15, 20'h00040, 8'd3);
      send_beats(4, -1, 8'd3, 8'h15, 20'h00040);
      finish_seg(1);

      // Back-pressure
      bp_mode = 1'b1;
      send_desc(8'h2A, 20'h12345, 8'd7);
      send_beats(8, -1, 8'd7, 8'h2A, 20'h12345);
      finish_seg(2);
      bp_mode = 1'b0;

      // 448-beat stream cut across four descriptors
      for (int s = 0; s < 4; s++) begin
         seg_len  = (s < 3) ? 127 : 63;
         seg_last = (s < 3) ? -1 : 63;
         send_desc(8'(8'h31 + s), 20'(20'h01000 + s), 8'(seg_len));
         send_beats(seg_len + 1, seg_last, 8'(seg_len), 8'(8'h31 + s), 20'(20'h01000 + s));
         finish_seg(3 + s);
      end
      chk("err_short_span", 64'(err_short), 64'd0);

      // Edge lengths
      send_desc(8'h40, 20'hABCDE, 8'd0);
      send_beats(1, -1, 8'd0, 8'h40, 20'hABCDE);
      finish_seg(7);
      send_desc(8'h41, 20'hFFFFF, 8'd255);
      send_beats(256, -1, 8'd255, 8'h41, 20'hFFFFF);
      finish_seg(8);
      chk("err_short_edge", 64'(err_short), 64'd0);

      // Short stream then a normal segment
      send_desc(8'h50, 20'h00500, 8'd9);
      send_beats(5, 4, 8'd9, 8'h50, 20'h00500);
      finish_seg(9);
      chk("err_short_set", 64'(err_short), 64'd1);
      send_desc(8'h51, 20'h00510, 8'd2);
      send_beats(3, -1, 8'd2, 8'h51, 20'h00510);
      finish_seg(10);
      chk("err_short_sticky", 64'(err_short), 64'd1);

      // Reset in the middle of a segment
      send_desc(8'h60, 20'h00600, 8'd5);
      send_beats(2, -1, 8'd5, 8'h60, 20'h00600);
      @(negedge clock);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      sb.delete();
      saved_done = done_cnt;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      repeat (4) @(negedge clock);
      #1;
      chk("no_done_after_reset", 64'(done_cnt), 64'(saved_done));
      send_desc(8'h61, 20'h00610, 8'd4);
      send_beats(5, -1, 8'd4, 8'h61, 20'h00610);
      finish_seg(saved_done + 1);
      chk("err_short_after_reset", 64'(err_short), 64'd0);
      chk("stall_flag_end", 64'(stall_flag), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
